// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Clock cycles per line bit, integer-truncated.
  function automatic int bit_ticks(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count. Writes into a full FIFO and reads
// from an empty one are ignored; full/empty reflect the count before any
// same-cycle access. DEPTH must be a power of two so pointers wrap freely.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards any stored contents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes are queued in a small FIFO and sent as
// 8N1 (or 8E1) frames, back-to-back with no idle bit while bytes remain.
//
// Write handshake: there is no ready signal. A byte is offered by holding
// dataReady high for one cycle with dataIn valid; it is accepted when full
// is low at that edge, otherwise it is dropped and overflow latches high.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 5_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [7:0]    dataIn,
  input  logic          dataReady,
  output logic          tx,
  output logic          busy,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output tx_state_t     state_o
);

  localparam int BIT_TICKS = bit_ticks(CLK_HZ, BAUD);
  localparam int TW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(BIT_TICKS - 1);

  tx_state_t   state_q;
  logic [TW-1:0] tick_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic        tx_q;
  logic        overflow_q;

  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        tick_last;
  logic        pop;

  assign tick_last = (tick_q == LAST_TICK);
  // Pop from IDLE, or on the last stop tick to chain the next frame.
  assign pop = !fifo_empty &&
               ((state_q == IDLE) || ((state_q == STOP) && tick_last));

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en_i   (dataReady),
    .wr_data_i (dataIn),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (full),
    .empty_o   (fifo_empty),
    .count_o   (count)
  );

  // Frame sequencer: bit timing, LSB-first shifting and registered line output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q  <= fifo_rd_data;
            parity_q <= ^fifo_rd_data;
            tx_q     <= 1'b0;
            tick_q   <= '0;
            state_q  <= START;
          end
        end
        START: begin
          if (tick_last) begin
            tick_q    <= '0;
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_last) begin
            tick_q <= '0;
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_last) begin
            tick_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_last) begin
            tick_q <= '0;
            if (pop) begin
              shift_q  <= fifo_rd_data;
              parity_q <= ^fifo_rd_data;
              tx_q     <= 1'b0;
              state_q  <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          tick_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Sticky drop flag, set on the edge that samples a write into a full FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (dataReady && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;
  assign state_o  = state_q;

endmodule
